iir_capture_readout: RTL and testbench
======================================

// Module: iir_capture_readout
// PURPOSE
//   On-chip capture buffer for the IIR filter output stream, the read side of the SNR/ENOB flow.
//   Stores DEPTH consecutive filter output samples in RAM after an arm request.
//   Drains them in order over a valid/ready stream to a host or serializer for offline SNR/ENOB analysis.
//   Sits directly after iir_filter.data_out in the same 48 kHz sample clock domain.
// PARAMETERS
//   DATA_WIDTH  32    sample width; matches the iir_filter data_out width, signed
//   DEPTH       1024  samples per capture; must be a power of two, >= 4
//   ADDR_W      10    $clog2(DEPTH)
//   CNT_W       16    width of the saturating drop counter
// PORTS
//   clk         in   1            sample clock, rising edge
//   rst_n       in   1            asynchronous active-low reset
//   sample_in   in   DATA_WIDTH   filter output sample (signed)
//   sample_vld  in   1            sample_in valid this cycle; tie to 1 for the every-clock capture
//   arm         in   1            single-cycle pulse: start a capture
//   abort       in   1            return to IDLE from any state
//   rd_data     out  DATA_WIDTH   captured sample, oldest first
//   rd_valid    out  1            rd_data valid
//   rd_ready    in   1            consumer accepts rd_data when rd_valid&&rd_ready
//   rd_last     out  1            qualifies the final word (index DEPTH-1)
//   busy        out  1            state != IDLE
//   done        out  1            1-cycle pulse on acceptance of the rd_last word
//   drop_cnt    out  CNT_W        samples with sample_vld=1 not stored since the last arm
// BEHAVIOUR
//   Reset (async assert, sync release)
//   - state=IDLE; wr_ptr=0; rd_ptr=0; drop_cnt=0.
//   - rd_valid, rd_last, done, busy = 0; rd_data = 0. RAM contents are undefined.
//   FSM: IDLE -> CAPTURE -> DRAIN -> IDLE
//   - IDLE: arm -> CAPTURE, wr_ptr=0, drop_cnt=0. sample_vld is ignored and not counted.
//   - CAPTURE: on each sample_vld, mem[wr_ptr]=sample_in and wr_ptr++.
//     A write at wr_ptr==DEPTH-1 moves to DRAIN in the next cycle.
//     The sample arriving in the same cycle as arm is not stored. Storing starts the cycle after arm.
//   - DRAIN: the RAM has a 1-cycle registered read. Use prefetch plus a 1-entry output register
//     (sub-module 2-deep skid) so that:
//     - the first rd_valid asserts no later than 2 cycles after the last capture write;
//     - with rd_ready held at 1, one word transfers per cycle with no bubbles;
//     - while rd_valid=1 && rd_ready=0, rd_data and rd_last hold stable and rd_valid stays 1.
//     - sample_vld here increments drop_cnt, which saturates at 2^CNT_W-1.
//   - Transfer of the rd_last word: done=1 for that cycle, state -> IDLE, rd_valid=0 in the next cycle.
//   - Order: word k equals the k-th stored sample, bit-exact, for k = 0..DEPTH-1.
//   Boundary conditions
//   - arm while busy: ignored. It does not restart the capture or clear drop_cnt.
//   - abort takes priority over arm and over all other events in the same cycle.
//     Next cycle: IDLE, rd_valid=0, no done pulse; drop_cnt is held.
//   - arm and abort in the same cycle while in IDLE: remain in IDLE.
//   - wr_ptr and rd_ptr never wrap inside one capture. Both clear on arm.
//   - rst_n assertion mid-CAPTURE or mid-DRAIN: outputs return to reset values immediately (async).
//   - sample_vld gaps in CAPTURE stall wr_ptr. There is no timeout.
// STRUCTURE
//   - Shared include iir_capture_defs.vh: state encodings ST_IDLE=2'd0, ST_CAPTURE=2'd1,
//     ST_DRAIN=2'd2, plus the default DEPTH and DATA_WIDTH.
//   - Sub-module iir_capture_ram: simple dual-port RAM with 1 write and 1 registered read port,
//     same clock, DATA_WIDTH x DEPTH, inferable as block RAM.
//   - Top level holds the FSM, pointers, prefetch/skid output stage, and the drop counter.
// TESTING (bench drives a ramp sample_in=n and, separately, the lfsr+sine+iir_filter chain)
//   1. arm, ramp with sample_vld=1, rd_ready=1
//      -> exactly 1024 words 0..1023, no bubbles after the first;
//         rd_last only on 1023; one done pulse; busy low the cycle after.
//   2. rd_ready toggled by a random pattern during DRAIN
//      -> rd_data stable while stalled; sequence still 0..1023; no drops or duplicates.
//   3. sample_vld=1 throughout DRAIN while rd_ready=0 for 100 cycles
//      -> drop_cnt increments by one per sample in DRAIN; stored data unaffected.
//   4. abort at capture word 500, then re-arm
//      -> IDLE next cycle, no done; the new capture starts at index 0 with a fresh ramp.
//   5. arm pulses during CAPTURE and DRAIN -> ignored; output identical to test 1.
//   6. rst_n low mid-DRAIN (word 300) -> rd_valid=0 and busy=0 immediately;
//      after release, arm gives a clean 1024-word capture.

Source files
------------

// File: rtl/iir_capture_readout_pkg.sv
// Shared types and defaults for the IIR output capture buffer.
// State encodings are fixed because offline tooling decodes them from debug taps.
package iir_capture_readout_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } cap_state_e;
endpackage

// File: rtl/iir_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// No reset on storage or read register so it maps onto block RAM.
module iir_capture_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/iir_capture_readout.sv
// Capture DEPTH filter samples after arm, then drain them oldest-first over valid/ready.
// Reads are prefetched into a 2-entry output queue so the stream runs bubble-free.
module iir_capture_readout
  import iir_capture_readout_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_vld,
  input  logic                  arm,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      drop_cnt
);
  cap_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  infl_q, infl_d, infl_last_q, infl_last_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic                  out_last_q, out_last_d, skid_last_q, skid_last_d;
  logic                  we, re, pop, last_wr;
  logic [1:0]            occ, n_left;
  logic [DATA_WIDTH-1:0] ram_q;

  iir_capture_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (sample_in),
    .re    (re),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = out_q;
  assign rd_last  = rd_valid && out_last_q;
  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = drop_q;
  assign pop      = rd_valid && rd_ready;
  assign done     = pop && out_last_q && !abort;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_d      = drop_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    we          = 1'b0;
    re          = 1'b0;
    last_wr     = (state_q == ST_CAPTURE) && sample_vld && (wr_ptr_q == ADDR_W'(DEPTH-1));
    // Slots already committed (queued + in flight) after this cycle's pop.
    occ         = cnt_q + {1'b0, infl_q} - {1'b0, pop};

    if (pop && cnt_q == 2'd2) begin
      out_d      = skid_q;
      out_last_d = skid_last_q;
    end
    n_left = cnt_q - {1'b0, pop};
    if (infl_q) begin
      if (n_left == 2'd0) begin
        out_d      = ram_q;
        out_last_d = infl_last_q;
      end else begin
        skid_d      = ram_q;
        skid_last_d = infl_last_q;
      end
    end
    cnt_d = n_left + {1'b0, infl_q};

    case (state_q)
      ST_IDLE: if (arm) begin
        state_d  = ST_CAPTURE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        drop_d   = '0;
      end
      ST_CAPTURE: if (sample_vld) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (last_wr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sample_vld && drop_q != '1) drop_d = drop_q + CNT_W'(1);
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Word 0 is fetched alongside the final write so rd_valid rises two cycles later.
    if ((state_q == ST_DRAIN || last_wr) && !rd_ptr_q[ADDR_W] && occ < 2'd2) begin
      re          = 1'b1;
      rd_ptr_d    = rd_ptr_q + (ADDR_W+1)'(1);
      infl_d      = 1'b1;
      infl_last_d = (rd_ptr_q[ADDR_W-1:0] == ADDR_W'(DEPTH-1));
    end

    if (abort) begin
      state_d  = ST_IDLE;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      we       = 1'b0;
      re       = 1'b0;
      cnt_d    = 2'd0;
      infl_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= '0;
      cnt_q       <= 2'd0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      skid_q      <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      skid_q      <= skid_d;
      skid_last_q <= skid_last_d;
    end
  end
endmodule

// File: tb/tb_iir_capture_readout.sv
// Randomized bench for iir_capture_readout against a queue-based capture/drain model.
module tb_iir_capture_readout;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sample_in;
  logic          sample_vld, arm, abort, rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last, busy, done;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  iir_capture_readout #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(10), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_vld(sample_vld),
    .arm(arm), .abort(abort), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 capturing, 2 draining
  int            phase = 0, rd_idx = 0, exp_drop = 0, cyc = 0;
  int            last_wr_cyc = 0, first_vld_cyc = -1, done_cyc = 0, n_done = 0;
  logic [DW-1:0] expq[$];
  logic          pv_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic model_reset();
    phase = 0; rd_idx = 0; exp_drop = 0; pv_stall = 1'b0; first_vld_cyc = -1;
    expq.delete();
  endtask

  task automatic step(input logic vld, input logic a, input logic ab, input logic rdy,
                      input logic [DW-1:0] din);
    logic xfer;
    sample_vld = vld; arm = a; abort = ab; rd_ready = rdy; sample_in = din;
    #1;
    chk("busy", busy, 64'(phase != 0));
    chk("drop_cnt", drop_cnt, 64'(exp_drop));
    if (pv_stall) begin
      chk("stall_vld", rd_valid, 1);
      chk("stall_data", rd_data, prev_data);
      chk("stall_last", rd_last, prev_last);
    end
    xfer = rd_valid && rdy;
    if (phase != 2) begin
      chk("vld_outside_drain", rd_valid, 0);
      chk("done_outside_drain", done, 0);
    end else begin
      if (rd_valid && first_vld_cyc < 0) begin
        first_vld_cyc = cyc;
        chk("first_vld_latency", 64'(cyc - last_wr_cyc <= 2), 1);
      end
      if (xfer) begin
        chk("rd_data", rd_data, expq[rd_idx]);
        chk("rd_last", rd_last, 64'(rd_idx == DEPTH-1));
        chk("done", done, 64'(rd_idx == DEPTH-1 && !ab));
      end else begin
        chk("done_no_xfer", done, 0);
      end
    end
    pv_stall  = rd_valid && !rdy && !ab;
    prev_data = rd_data;
    prev_last = rd_last;
    if (ab) begin
      phase = 0;
      pv_stall = 1'b0;
    end else begin
      case (phase)
        0: if (a) begin
          model_reset();
          phase = 1;
        end
        1: if (vld) begin
          expq.push_back(din);
          if (expq.size() == DEPTH) begin
            phase = 2;
            last_wr_cyc = cyc;
          end
        end
        default: begin
          if (vld && exp_drop < 65535) exp_drop++;
          if (xfer) begin
            if (rd_idx == DEPTH-1) begin
              phase = 0;
              n_done++;
              done_cyc = cyc;
            end
            rd_idx++;
          end
        end
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  // mode: 1 ramp/ready, 2 random ready+gaps, 3 100-cycle stall, 5 stray arms
  task automatic run(input int mode, input int abort_at, input int rst_at);
    int            ramp, dcnt;
    logic          v, r, a, ab;
    logic [DW-1:0] d;
    ramp = 0; dcnt = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k < 20000 && phase != 0; k++) begin
      v = 1'b1; r = 1'b1; a = 1'b0; ab = 1'b0;
      d = DW'(ramp);
      if (mode == 2) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 1) != 0);
        d = $urandom;
      end
      if (mode == 3) r = (dcnt >= 100);
      if (mode == 5) a = ($urandom_range(0, 15) == 0);
      if (abort_at >= 0 && phase == 1 && expq.size() == abort_at) ab = 1'b1;
      if (rst_at >= 0 && phase == 2 && rd_idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", rd_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_drop", drop_cnt, 0);
        model_reset();
        sample_vld = 1'b0; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc += 2;
        break;
      end
      if (phase == 2) dcnt++;
      if (v && phase == 1) ramp++;
      step(v, a, ab, r, d);
    end
    if (phase != 0) begin
      chk("timeout", 64'(phase), 0);
      model_reset();
    end
  endtask

  initial begin
    int dn0;
    rst_n = 1'b0; sample_in = '0; sample_vld = 1'b0; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_vld", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    dn0 = n_done;
    run(1, -1, -1);
    chk("t1_done_cnt", 64'(n_done - dn0), 1);
    chk("t1_no_bubble", 64'(done_cyc - first_vld_cyc), DEPTH-1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);

    run(2, -1, -1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);

    run(3, -1, -1);
    chk("t3_drop_total", drop_cnt, 64'(done_cyc - last_wr_cyc));
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);

    dn0 = n_done;
    run(1, 500, -1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    chk("t4_no_done", 64'(n_done - dn0), 0);
    run(1, -1, -1);
    chk("t4_rearm_done", 64'(n_done - dn0), 1);

    step(1'b1, 1'b1, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);

    dn0 = n_done;
    run(5, -1, -1);
    chk("t5_done_cnt", 64'(n_done - dn0), 1);
    chk("t5_no_bubble", 64'(done_cyc - first_vld_cyc), DEPTH-1);

    run(1, -1, 300);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    dn0 = n_done;
    run(1, -1, -1);
    chk("t6_clean_done", 64'(n_done - dn0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
